// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding, geometry defaults and coordinate widths for the box-draw control.
package draw_pkg;

    localparam int BOX_PIXELS_DEF = 16;
    localparam int SCREEN_W_DEF   = 160;
    localparam int SCREEN_H_DEF   = 120;
    localparam int X_W            = 8;
    localparam int Y_W            = 7;
    localparam int COLOUR_W       = 3;

    typedef enum logic [2:0] {
        S_LOAD_X      = 3'd0,
        S_LOAD_X_WAIT = 3'd1,
        S_LOAD_Y      = 3'd2,
        S_LOAD_Y_WAIT = 3'd3,
        S_DRAW        = 3'd4,
        S_DONE        = 3'd5
`ifdef DRAW_CLEAR_EN
        ,
        S_CLEAR       = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - 2-D raster wrap counter (x fastest) with enable and a last-position flag.
module sweep_counter #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          x_wrap;
    logic          y_wrap;

    assign x_wrap = (x_q == XW'(W - 1));
    assign y_wrap = (y_q == YW'(H - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            if (x_wrap) begin
                x_q <= '0;
                y_q <= y_wrap ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_wrap && y_wrap;

endmodule

// File: rtl/draw_control.sv
// rtl/draw_control.sv - box-draw control FSM: X/Y load strobes, BOX_PIXELS plot burst, done pulse.
// Defining DRAW_CLEAR_EN adds a full-screen clear sweep entered from S_LOAD_X.
module draw_control
    import draw_pkg::*;
#(
    parameter int BOX_PIXELS = BOX_PIXELS_DEF
`ifdef DRAW_CLEAR_EN
    ,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
`ifdef DRAW_CLEAR_EN
    input  logic           clear,
    output logic           clr_active,
    output logic [X_W-1:0] clr_x,
    output logic [Y_W-1:0] clr_y,
`endif
    output logic           ld_x,
    output logic           ld_y,
    output logic           ld_colour,
    output logic           enable,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int               CNT_W    = $clog2(BOX_PIXELS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOX_PIXELS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             ld_x_q, ld_y_q, enable_q, plot_q, busy_q, done_q;
    logic             in_clear_d;

`ifdef DRAW_CLEAR_EN
    logic sweep_last;
    logic clr_active_q;

    sweep_counter #(
        .W  (SCREEN_W),
        .H  (SCREEN_H),
        .XW (X_W),
        .YW (Y_W)
    ) u_sweep (
        .clk_i  (clock),
        .rst_i  (reset),
        .en_i   (state_q == S_CLEAR),
        .x_o    (clr_x),
        .y_o    (clr_y),
        .last_o (sweep_last)
    );

    assign in_clear_d = (state_d == S_CLEAR);
    assign clr_active = clr_active_q;
`else
    assign in_clear_d = 1'b0;
`endif

    // armed blocks a key still held from the previous burst from starting a new load.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        armed_d = go ? armed_q : 1'b1;
        case (state_q)
            S_LOAD_X: begin
`ifdef DRAW_CLEAR_EN
                if (clear)
                    state_d = S_CLEAR;
                else
`endif
                if (go && armed_q)
                    state_d = S_LOAD_X_WAIT;
            end
            S_LOAD_X_WAIT: if (!go) state_d = S_LOAD_Y;
            S_LOAD_Y:      if (go)  state_d = S_LOAD_Y_WAIT;
            S_LOAD_Y_WAIT: if (!go) state_d = S_DRAW;
            S_DRAW: begin
                armed_d = 1'b0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_LOAD_X;
`ifdef DRAW_CLEAR_EN
            S_CLEAR: begin
                armed_d = 1'b0;
                if (sweep_last)
                    state_d = S_DONE;
            end
`endif
            default: state_d = S_LOAD_X;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOAD_X;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            ld_x_q   <= 1'b0;
            ld_y_q   <= 1'b0;
            enable_q <= 1'b0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DRAW_CLEAR_EN
            clr_active_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            ld_x_q   <= (state_d == S_LOAD_X_WAIT);
            ld_y_q   <= (state_d == S_LOAD_Y_WAIT);
            enable_q <= (state_d == S_DRAW);
            plot_q   <= (state_d == S_DRAW) || in_clear_d;
            busy_q   <= (state_d == S_DRAW) || in_clear_d;
            done_q   <= (state_d == S_DONE);
`ifdef DRAW_CLEAR_EN
            clr_active_q <= in_clear_d;
`endif
        end
    end

    assign ld_x      = ld_x_q;
    assign ld_y      = ld_y_q;
    assign ld_colour = ld_y_q;
    assign enable    = enable_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_draw_control.sv
// tb/tb_draw_control.sv - randomized and directed bench for draw_control against a phase-level reference model.
module tb_draw_control;

    localparam int BOX   = 16;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam int M_IDLE  = 0;
    localparam int M_XHELD = 1;
    localparam int M_YWAIT = 2;
    localparam int M_YHELD = 3;
    localparam int M_BURST = 4;
    localparam int M_DONE  = 5;
    localparam int M_SWEEP = 6;

    logic clock;
    logic reset;
    logic go;
    logic ld_x, ld_y, ld_colour, enable, plot, busy, done;
`ifdef DRAW_CLEAR_EN
    logic       clear;
    logic       clr_active;
    logic [7:0] clr_x;
    logic [6:0] clr_y;
`endif

    draw_control dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
`ifdef DRAW_CLEAR_EN
        .clear      (clear),
        .clr_active (clr_active),
        .clr_x      (clr_x),
        .clr_y      (clr_y),
`endif
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_colour  (ld_colour),
        .enable     (enable),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: which phase of the press/burst protocol we are in, plus pixels left.
    int m_stage;
    int m_left;
    int m_pix;
    bit m_need_rel;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_stage    <= M_IDLE;
            m_left     <= 0;
            m_pix      <= 0;
            m_need_rel <= 1'b0;
        end else begin
            case (m_stage)
                M_IDLE: begin
`ifdef DRAW_CLEAR_EN
                    if (clear) begin
                        m_stage <= M_SWEEP;
                        m_pix   <= 0;
                    end else
`endif
                    if (go && !m_need_rel) m_stage <= M_XHELD;
                end
                M_XHELD: if (!go) m_stage <= M_YWAIT;
                M_YWAIT: if (go)  m_stage <= M_YHELD;
                M_YHELD: if (!go) begin
                    m_stage <= M_BURST;
                    m_left  <= BOX;
                end
                M_BURST: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_stage <= M_DONE;
                end
                M_SWEEP: begin
                    if (m_pix == SCR_W * SCR_H - 1) m_stage <= M_DONE;
                    else m_pix <= m_pix + 1;
                end
                default: m_stage <= M_IDLE;
            endcase
            if (m_stage == M_BURST || m_stage == M_SWEEP) m_need_rel <= 1'b1;
            else if (!go) m_need_rel <= 1'b0;
        end
    end

    logic [6:0] act, expv;
    assign act  = {ld_x, ld_y, ld_colour, enable, plot, busy, done};
    assign expv = {m_stage == M_XHELD, m_stage == M_YHELD, m_stage == M_YHELD,
                   m_stage == M_BURST,
                   m_stage == M_BURST || m_stage == M_SWEEP,
                   m_stage == M_BURST || m_stage == M_SWEEP,
                   m_stage == M_DONE};

    int checks   = 0;
    int failures = 0;
    int n_ldx, n_ldy, n_ldc, n_en, n_plot, n_done, n_clr;
    int run_len  = 0;
    int last_x, last_y;
    int cyc      = 0;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic zero_counts();
        n_ldx = 0; n_ldy = 0; n_ldc = 0; n_en = 0; n_plot = 0; n_done = 0; n_clr = 0;
    endtask

    // Samples and checks at the falling edge, then drives the next inputs.
    task automatic tick(input logic g, input logic r);
        @(negedge clock);
        cyc++;
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, expv);
        end
`ifdef DRAW_CLEAR_EN
        checks++;
        if ({clr_active, clr_x, clr_y} !== {m_stage == M_SWEEP,
                (m_stage == M_SWEEP) ? 8'(m_pix % SCR_W) : 8'd0,
                (m_stage == M_SWEEP) ? 7'(m_pix / SCR_W) : 7'd0}) begin
            failures++;
            $display("FAIL sweep cyc=%0d actual=%b/%0d/%0d required_pix=%0d",
                     cyc, clr_active, clr_x, clr_y, m_pix);
        end
        if (clr_active) n_clr++;
        if (plot && clr_active) begin last_x = clr_x; last_y = clr_y; end
`endif
        if (ld_x) n_ldx++;
        if (ld_y) n_ldy++;
        if (ld_colour) n_ldc++;
        if (enable) n_en++;
        if (plot) n_plot++;
        if (done) n_done++;
        if (reset) run_len = 0;
        else if (enable) run_len++;
        else if (run_len > 0) begin
            check("burst_len", run_len, BOX);
            run_len = 0;
        end
        #1;
        go    = g;
        reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic seq(input int xlen, input int ylen);
        for (int i = 0; i < xlen; i++) tick(1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < ylen; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        bit found;
        logic g_state;
        int hold;
        reset = 1'b1;
        go    = 1'b0;
`ifdef DRAW_CLEAR_EN
        clear = 1'b0;
`endif
        zero_counts();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("reset_outputs", int'(act), 0);
        idle(2);

        // Basic 3-cycle X press, 2-cycle Y press.
        zero_counts();
        seq(3, 2);
        idle(25);
        check("t1_ld_x", n_ldx, 3);
        check("t1_ld_y", n_ldy, 2);
        check("t1_ld_colour", n_ldc, 2);
        check("t1_plot", n_plot, 16);
        check("t1_enable", n_en, 16);
        check("t1_done", n_done, 1);

        // Key held through burst and done must not start a new load.
        seq(2, 2);
        zero_counts();
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
        check("t2_no_ld_x", n_ldx, 0);
        check("t2_plot", n_plot, 16);
        check("t2_done", n_done, 1);
        zero_counts();
        idle(2);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("t2_rearm_ld_x", n_ldx, 2);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        idle(22);

        // Reset partway through a burst.
        seq(2, 2);
        zero_counts();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0);
            if (n_plot >= 7) begin found = 1'b1; break; end
        end
        check("t3_plot7_reached", int'(found), 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("t3_reset_abort", int'(act), 0);
        zero_counts();
        seq(2, 3);
        idle(25);
        check("t3_plot_after", n_plot, 16);
        check("t3_ld_y_after", n_ldy, 3);

        // go pulse inside the burst.
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        zero_counts();
        idle(4);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        idle(20);
        check("t4_plot", n_plot, 16);
        check("t4_no_ld_x", n_ldx, 0);
        check("t4_no_ld_y", n_ldy, 0);
        check("t4_done", n_done, 1);

        // Random key activity with occasional resets.
        g_state = 1'b0;
        hold    = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                g_state = ~g_state;
                hold    = $urandom_range(1, 6);
            end
            hold--;
            tick(g_state, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end
        tick(1'b0, 1'b1);
        idle(3);

`ifdef DRAW_CLEAR_EN
        // clear wins over go in S_LOAD_X.
        zero_counts();
        clear = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 19400; i++) begin
            tick(1'b0, 1'b0);
            if (n_done > 0) break;
        end
        check("clr_plot", n_plot, SCR_W * SCR_H);
        check("clr_last_x", last_x, SCR_W - 1);
        check("clr_last_y", last_y, SCR_H - 1);
        check("clr_enable", n_en, 0);
        check("clr_done", n_done, 1);
        idle(2);

        // clear in S_LOAD_Y is ignored.
        zero_counts();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        clear = 1'b1;
        idle(2);
        clear = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        idle(22);
        check("clr_y_ignored_plot", n_plot, 16);
        check("clr_y_ignored_active", n_clr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
